// File: rtl/kronos_types.sv
// Shared types and constants for the Kronos machine-mode trap sequencer.
// The SLEEP state exists only when KRONOS_WFI_EN is defined.
package kronos_types;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ENTRY  = 3'd1,
        RETURN = 3'd2,
        JUMP   = 3'd3
`ifdef KRONOS_WFI_EN
        ,
        SLEEP  = 3'd4
`endif
    } trap_state_e;

    localparam int IRQ_FLAG_BIT = 31;

    localparam logic [3:0] ECALL_MACHINE = 4'd11;
    localparam logic [3:0] ILLEGAL_INSTR = 4'd2;
    localparam logic [3:0] BREAKPOINT    = 4'd3;

    // mcause for an interrupt: code in the low bits, interrupt flag in the MSB.
    function automatic logic [31:0] irq_cause(input logic [3:0] code);
        logic [31:0] c;
        c = {28'b0, code};
        c[IRQ_FLAG_BIT] = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/kronos_trap_timeout.sv
// Saturating cycle counter with synchronous clear; expired pulses on the
// cycle the count would reach LIMIT, and the counter then restarts from zero.
module kronos_trap_timeout #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rstz,
    input  logic en,
    input  logic clr,
    output logic expired
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count;

    assign expired = en && !clr && (count == CNT_W'(LIMIT - 1));

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            count <= '0;
        end else if (clr || expired) begin
            count <= '0;
        end else if (en && (count != CNT_W'(LIMIT))) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/kronos_trap_sequencer.sv
// WB-stage machine-mode trap sequencer: picks exception/interrupt/mret/retire per
// instruction boundary and drives CSR strobes. KRONOS_WFI_EN enables WFI sleep.
module kronos_trap_sequencer
    import kronos_types::*;
#(
    parameter int JUMP_TIMEOUT = 4,
    parameter int EXC_CAUSE_W  = 4
) (
    input  logic                   clk,
    input  logic                   rstz,
    input  logic                   wb_vld,
    output logic                   wb_rdy,
    input  logic                   exc_vld,
    input  logic [EXC_CAUSE_W-1:0] exc_cause,
    input  logic [31:0]            exc_tval,
    input  logic                   is_mret,
    input  logic                   is_wfi,
    input  logic                   core_interrupt,
    input  logic [3:0]             core_interrupt_cause,
    output logic                   activate_trap,
    output logic                   return_trap,
    output logic [31:0]            trap_cause,
    output logic [31:0]            trap_value,
    input  logic                   trap_jump,
    output logic                   flush,
    output logic                   instret,
    output logic                   seq_err
);

    trap_state_e state, state_nxt;
    logic        latch_exc;
    logic        latch_irq;
    logic        jump_en;
    logic        jump_clr;
    logic        jump_expired;

`ifdef KRONOS_WFI_EN
    // Interrupt seen while asleep; wake-up is taken one cycle after sampling.
    logic        irq_p0;

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            irq_p0 <= 1'b0;
        end else begin
            irq_p0 <= (state == SLEEP) && core_interrupt;
        end
    end
`else
    logic        unused_wfi;
    assign unused_wfi = is_wfi;
`endif

    assign jump_en  = (state == JUMP) && !trap_jump;
    assign jump_clr = (state != JUMP) || trap_jump;

    kronos_trap_timeout #(
        .LIMIT   (JUMP_TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rstz    (rstz),
        .en      (jump_en),
        .clr     (jump_clr),
        .expired (jump_expired)
    );

    always_comb begin
        state_nxt = state;
        wb_rdy    = 1'b0;
        instret   = 1'b0;
        flush     = 1'b0;
        latch_exc = 1'b0;
        latch_irq = 1'b0;
        case (state)
            IDLE: begin
                if (wb_vld) begin
                    if (exc_vld) begin
                        wb_rdy    = 1'b1;
                        latch_exc = 1'b1;
                        state_nxt = ENTRY;
                    end else if (core_interrupt) begin
                        // Instruction is held and re-executed after the handler.
                        latch_irq = 1'b1;
                        state_nxt = ENTRY;
                    end else if (is_mret) begin
                        wb_rdy    = 1'b1;
                        instret   = 1'b1;
                        state_nxt = RETURN;
`ifdef KRONOS_WFI_EN
                    end else if (is_wfi) begin
                        wb_rdy    = 1'b1;
                        instret   = 1'b1;
                        state_nxt = SLEEP;
`endif
                    end else begin
                        wb_rdy    = 1'b1;
                        instret   = 1'b1;
                    end
                end
            end
            ENTRY, RETURN: begin
                state_nxt = JUMP;
            end
            JUMP: begin
                if (trap_jump) begin
                    flush     = 1'b1;
                    state_nxt = IDLE;
                end else if (jump_expired) begin
                    state_nxt = IDLE;
                end
            end
`ifdef KRONOS_WFI_EN
            SLEEP: begin
                if (irq_p0) begin
                    latch_irq = 1'b1;
                    state_nxt = ENTRY;
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state         <= IDLE;
            activate_trap <= 1'b0;
            return_trap   <= 1'b0;
            trap_cause    <= '0;
            trap_value    <= '0;
            seq_err       <= 1'b0;
        end else begin
            state         <= state_nxt;
            activate_trap <= (state_nxt == ENTRY);
            return_trap   <= (state_nxt == RETURN);
            seq_err       <= seq_err | jump_expired;
            if (latch_exc) begin
                trap_cause <= {{(32 - EXC_CAUSE_W){1'b0}}, exc_cause};
                trap_value <= exc_tval;
            end else if (latch_irq) begin
                trap_cause <= irq_cause(core_interrupt_cause);
                trap_value <= '0;
            end
        end
    end

endmodule
